// File: rtl/machine_rr_arbiter_if.sv
// Requester, datapath and response signals of machine_rr_arbiter.
// master: the arbiter side. slave: requesters, datapath and response consumer.
interface machine_rr_arbiter_if;
    localparam int unsigned OP_W  = 8;
    localparam int unsigned RES_W = 12;

    logic             req0_valid;
    logic [OP_W-1:0]  req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [OP_W-1:0]  req1_data;
    logic             req1_ready;
    logic [OP_W-1:0]  dp_x;
    logic             dp_en;
    logic [RES_W-1:0] dp_result;
    logic             rsp_valid;
    logic             rsp_id;
    logic [RES_W-1:0] rsp_data;
    logic             rsp_ready;
    logic             busy;

    modport master (
        input  req0_valid, req0_data, req1_valid, req1_data, dp_result, rsp_ready,
        output req0_ready, req1_ready, dp_x, dp_en, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        output req0_valid, req0_data, req1_valid, req1_data, dp_result, rsp_ready,
        input  req0_ready, req1_ready, dp_x, dp_en, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/machine_rr_arbiter.sv
// Two-requester round-robin front end for a shared fixed-latency datapath.
// Define MACHINE_ARB_STATS_EN to add saturating per-requester grant counters.
module machine_rr_arbiter #(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 system1000,
    input  logic                 system1000_rstn,
`ifdef MACHINE_ARB_STATS_EN
    output logic [CNT_W-1:0]     grant0_cnt,
    output logic [CNT_W-1:0]     grant1_cnt,
`endif
    machine_rr_arbiter_if.master bus
);
    localparam int unsigned OP_W   = 8;
    localparam int unsigned RES_W  = 12;
    localparam int unsigned WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e             state_q;
    logic               ptr_q;
    logic [OP_W-1:0]    dp_x_q;
    logic               dp_en_q;
    logic               rsp_valid_q;
    logic               rsp_id_q;
    logic [RES_W-1:0]   rsp_data_q;
    logic               busy_q;
    logic [WAIT_W-1:0]  wait_cnt_q;
`ifdef MACHINE_ARB_STATS_EN
    logic [CNT_W-1:0]   grant0_q;
    logic [CNT_W-1:0]   grant1_q;
`endif

    logic winner_vld_c;
    logic winner_id_c;
    logic accept_c;

    // Pointer only breaks ties; a lone requester always wins.
    always_comb begin
        winner_vld_c = 1'b0;
        winner_id_c  = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            winner_vld_c = 1'b1;
            winner_id_c  = ptr_q;
        end else if (bus.req1_valid) begin
            winner_vld_c = 1'b1;
            winner_id_c  = 1'b1;
        end else if (bus.req0_valid) begin
            winner_vld_c = 1'b1;
            winner_id_c  = 1'b0;
        end
    end

    assign accept_c       = system1000_rstn && (state_q == ST_IDLE) && winner_vld_c;
    assign bus.req0_ready = accept_c && !winner_id_c;
    assign bus.req1_ready = accept_c && winner_id_c;

    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 1'b0;
            dp_x_q      <= '0;
            dp_en_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            wait_cnt_q  <= '0;
`ifdef MACHINE_ARB_STATS_EN
            grant0_q    <= '0;
            grant1_q    <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        dp_x_q   <= winner_id_c ? bus.req1_data : bus.req0_data;
                        rsp_id_q <= winner_id_c;
                        ptr_q    <= !winner_id_c;
                        dp_en_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ST_ISSUE;
`ifdef MACHINE_ARB_STATS_EN
                        if (!winner_id_c && !(&grant0_q)) grant0_q <= grant0_q + CNT_W'(1);
                        if (winner_id_c && !(&grant1_q))  grant1_q <= grant1_q + CNT_W'(1);
`endif
                    end
                end
                ST_ISSUE: begin
                    dp_en_q    <= 1'b0;
                    wait_cnt_q <= WAIT_W'(LATENCY);
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Counter at 1 marks the cycle the datapath result is valid.
                    if (wait_cnt_q == WAIT_W'(1)) begin
                        rsp_data_q  <= bus.dp_result;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - WAIT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.dp_x      = dp_x_q;
    assign bus.dp_en     = dp_en_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = busy_q;
`ifdef MACHINE_ARB_STATS_EN
    assign grant0_cnt    = grant0_q;
    assign grant1_cnt    = grant1_q;
`endif
endmodule

// File: tb/tb_machine_rr_arbiter.sv
// Bench for machine_rr_arbiter: directed scenarios plus random traffic against a transaction-timeline model.
module tb_machine_rr_arbiter;
    localparam int unsigned LAT  = 4;
    localparam int unsigned CW   = 2;
    localparam int          CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    machine_rr_arbiter_if ifc ();
`ifdef MACHINE_ARB_STATS_EN
    logic [CW-1:0] g0_cnt;
    logic [CW-1:0] g1_cnt;
`endif

    machine_rr_arbiter #(.LATENCY(LAT), .CNT_W(CW)) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
`ifdef MACHINE_ARB_STATS_EN
        .grant0_cnt      (g0_cnt),
        .grant1_cnt      (g1_cnt),
`endif
        .bus             (ifc)
    );

    // Datapath: {4'hF, operand} visible only in the LAT-th cycle after the dp_en cycle.
    int unsigned dpc = 0;
    logic [7:0]  dpv;
    always @(posedge clk) begin
        if (ifc.dp_en) begin
            dpc <= LAT;
            dpv <= ifc.dp_x;
        end else if (dpc != 0) begin
            dpc <= dpc - 1;
        end
    end
    assign ifc.dp_result = (dpc == 1) ? {4'hF, dpv} : 12'h000;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: m_t counts cycles since acceptance (1 = dp_en cycle, >= LAT+2 = response held).
    bit          m_busy = 1'b0;
    int          m_t    = 0;
    bit          m_ptr  = 1'b0;
    logic [7:0]  m_x    = 8'h00;
    bit          m_id   = 1'b0;
    logic [11:0] m_rsp  = 12'h000;
    int          m_g0   = 0;
    int          m_g1   = 0;

    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    int          glog[$];
    logic [11:0] rlog[$];

    task automatic drive();
        ifc.req0_valid = (q0.size() != 0);
        ifc.req0_data  = (q0.size() != 0) ? q0[0] : 8'h00;
        ifc.req1_valid = (q1.size() != 0);
        ifc.req1_data  = (q1.size() != 0) ? q1[0] : 8'h00;
    endtask

    task automatic tick();
        bit w_vld, w_id, acc0, acc1;
        drive();
        @(negedge clk);
        w_vld = ifc.req0_valid || ifc.req1_valid;
        w_id  = (ifc.req0_valid && ifc.req1_valid) ? m_ptr : ifc.req1_valid;
        acc0  = rstn && !m_busy && w_vld && !w_id;
        acc1  = rstn && !m_busy && w_vld && w_id;
        chk("req0_ready", 32'(ifc.req0_ready), 32'(acc0));
        chk("req1_ready", 32'(ifc.req1_ready), 32'(acc1));
        chk("busy",       32'(ifc.busy),       32'(m_busy));
        chk("dp_en",      32'(ifc.dp_en),      32'(m_busy && m_t == 1));
        chk("rsp_valid",  32'(ifc.rsp_valid),  32'(m_busy && m_t >= int'(LAT) + 2));
        chk("dp_x",       32'(ifc.dp_x),       32'(m_x));
        chk("rsp_id",     32'(ifc.rsp_id),     32'(m_id));
        chk("rsp_data",   32'(ifc.rsp_data),   32'(m_rsp));
`ifdef MACHINE_ARB_STATS_EN
        chk("grant0_cnt", 32'(g0_cnt), 32'(m_g0));
        chk("grant1_cnt", 32'(g1_cnt), 32'(m_g1));
`endif
        if (rstn && ifc.req0_ready && ifc.req0_valid) glog.push_back(0);
        if (rstn && ifc.req1_ready && ifc.req1_valid) glog.push_back(1);
        if (rstn && ifc.rsp_valid && ifc.rsp_ready)   rlog.push_back(ifc.rsp_data);

        if (!rstn) begin
            m_busy = 1'b0; m_t = 0; m_ptr = 1'b0; m_x = 8'h00;
            m_id = 1'b0; m_rsp = 12'h000; m_g0 = 0; m_g1 = 0;
        end else if (!m_busy) begin
            if (acc0 || acc1) begin
                m_busy = 1'b1;
                m_t    = 1;
                m_id   = acc1;
                m_x    = acc1 ? ifc.req1_data : ifc.req0_data;
                m_ptr  = !acc1;
                if (acc0 && m_g0 < CMAX) m_g0++;
                if (acc1 && m_g1 < CMAX) m_g1++;
            end
        end else if (m_t == int'(LAT) + 1) begin
            m_rsp = {4'hF, m_x};
            m_t++;
        end else if (m_t >= int'(LAT) + 2) begin
            if (ifc.rsp_ready) m_busy = 1'b0;
        end else begin
            m_t++;
        end

        @(posedge clk);
        #1;
        if (acc0) void'(q0.pop_front());
        if (acc1) void'(q1.pop_front());
    endtask

    initial begin
        rstn          = 1'b0;
        ifc.rsp_ready = 1'b0;
        q0.push_back(8'h3C);
        repeat (3) tick();

        // Single request from requester 0.
        rstn          = 1'b1;
        ifc.rsp_ready = 1'b1;
        rlog.delete();
        repeat (LAT + 6) tick();
        chk("single_rsp_cnt", 32'(rlog.size()), 32'd1);
        if (rlog.size() != 0) chk("single_rsp", 32'(rlog[0]), 32'h0F3C);

        // Contention from reset: grants alternate starting with requester 0.
        rstn = 1'b0; tick(); rstn = 1'b1;
        glog.delete(); rlog.delete();
        q0.push_back(8'h11); q0.push_back(8'h11);
        q1.push_back(8'h22); q1.push_back(8'h22);
        repeat (4 * (LAT + 3) + 4) tick();
        chk("cont_grants", 32'(glog.size()), 32'd4);
        chk("cont_rsps",   32'(rlog.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < glog.size()) chk("cont_grant_order", 32'(glog[i]), 32'(i % 2));
            if (i < rlog.size()) chk("cont_rsp_order", 32'(rlog[i]), (i % 2 == 1) ? 32'h0F22 : 32'h0F11);
        end

        // Backpressure: hold rsp_ready low for 5 response cycles with a competing request.
        ifc.rsp_ready = 1'b0;
        q0.push_back(8'h5A);
        for (int k = 0; k < 40 && !(m_busy && m_t >= int'(LAT) + 2); k++) tick();
        chk("bp_reach_resp", 32'(m_busy && m_t >= int'(LAT) + 2), 32'd1);
        q1.push_back(8'h66);
        repeat (5) tick();
        chk("bp_hold_valid", 32'(ifc.rsp_valid), 32'd1);
        chk("bp_hold_data",  32'(ifc.rsp_data),  32'h0F5A);
        ifc.rsp_ready = 1'b1;
        tick();
        chk("bp_idle", 32'(ifc.busy), 32'd0);
        repeat (LAT + 6) tick();

        // Reset in the middle of WAIT discards the transaction.
        q0.push_back(8'h77);
        for (int k = 0; k < 20 && !(m_busy && m_t == 3); k++) tick();
        chk("rst_reach_wait", 32'(m_busy && m_t == 3), 32'd1);
        rlog.delete();
        rstn = 1'b0; tick(); rstn = 1'b1;
        chk("rst_busy",      32'(ifc.busy),      32'd0);
        chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        repeat (LAT + 8) tick();
        chk("rst_no_stale", 32'(rlog.size()), 32'd0);

        // Five requester-1 grants: the narrow counter saturates.
        rstn = 1'b0; tick(); rstn = 1'b1;
        glog.delete();
        for (int i = 0; i < 5; i++) q1.push_back(8'(8'h80 + i));
        repeat (5 * (LAT + 3) + 6) tick();
        chk("stat_grants", 32'(glog.size()), 32'd5);
`ifdef MACHINE_ARB_STATS_EN
        chk("stat_g1_sat", 32'(g1_cnt), 32'd3);
        chk("stat_g0_zero", 32'(g0_cnt), 32'd0);
`endif

        // Random traffic with occasional resets.
        repeat (3000) begin
            if (q0.size() < 2 && $urandom_range(3) == 0) q0.push_back(8'($urandom));
            if (q1.size() < 2 && $urandom_range(3) == 0) q1.push_back(8'($urandom));
            ifc.rsp_ready = ($urandom_range(3) != 0);
            rstn          = ($urandom_range(399) != 0);
            tick();
        end
        rstn = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/machine_rr_arbiter.md
MACHINE_RR_ARBITER -- requirements
Module: machine_rr_arbiter

Interface
REQ-001 Parameter: LATENCY, 1, cycles from dp_en to valid dp_result (legal 1..15).
REQ-002 Parameter: CNT_W, 16, width of grant statistics counters.
REQ-003 Port: system1000  in  1  clock; all logic rising-edge.
REQ-004 Port: system1000_rstn  in  1  reset, synchronous, active-low.
REQ-005 Port: req0_valid  in  1  requester 0 has operand.
REQ-006 Port: req0_data  in  8  requester 0 operand.
REQ-007 Port: req0_ready  out  1  requester 0 operand accepted this cycle.
REQ-008 Port: req1_valid / req1_data / req1_ready  in/in/out  1/8/1  requester 1, same meaning.
REQ-009 Port: dp_x  out  8  operand to shared Machine datapath.
REQ-010 Port: dp_en  out  1  operand strobe to datapath.
REQ-011 Port: dp_result  in  12  datapath result.
REQ-012 Port: rsp_valid  out  1  response available.
REQ-013 Port: rsp_id  out  1  requester index owning response.
REQ-014 Port: rsp_data  out  12  captured result.
REQ-015 Port: rsp_ready  in  1  consumer accepts response.
REQ-016 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM SHALL have states IDLE, ISSUE, WAIT, RESP; one transaction in flight at a time.
REQ-018 IDLE: winner = requester with valid; both valid -> requester selected by priority pointer; reqN_ready SHALL be high combinationally only for winner, only in IDLE.
REQ-019 On acceptance SHALL register operand into dp_x, winner into rsp_id, go ISSUE.
REQ-020 ISSUE: dp_en high exactly one cycle; load wait counter with LATENCY; go WAIT.
REQ-021 WAIT: decrement counter each cycle; when counter reaches 1, capture dp_result into rsp_data and go RESP.
REQ-022 dp_x SHALL remain stable from ISSUE until return to IDLE.
REQ-023 RESP: rsp_valid high; rsp_id/rsp_data stable until rsp_ready sampled high; then go IDLE.
REQ-024 Priority pointer SHALL point to the requester not granted last; update on acceptance.
REQ-025 No requester valid in IDLE -> stay IDLE, both ready low, dp_en low.
REQ-026 Request arriving in ISSUE/WAIT/RESP SHALL wait (ready low); no drop, no reorder.
REQ-027 rsp_ready high outside RESP SHALL be ignored.
REQ-028 Minimum transaction length: LATENCY+3 cycles with rsp_ready held high.

Reset
REQ-029 rstn low at rising edge SHALL force IDLE, pointer=0 (requester 0 first), dp_x=0, dp_en=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, counters=0.
REQ-030 Reset mid-transaction SHALL discard in-flight operand and result; no response emitted afterward.
REQ-031 req0_ready/req1_ready SHALL be low while rstn low.

Configuration
REQ-032 Macro MACHINE_ARB_STATS_EN defined: ports grant0_cnt, grant1_cnt (out, CNT_W) present; each increments on its requester's acceptance, saturates at all-ones, cleared by reset.
REQ-033 Macro undefined: stats ports and counters absent; all other behaviour identical.

Verification
(Bench datapath model: dp_result = {4'hF, dp_x} valid LATENCY cycles after dp_en.)
REQ-034 Single request: req0 valid, data 0x3C, rsp_ready=1, LATENCY=1 -> dp_en one pulse, rsp_valid with rsp_id=0, rsp_data=0xF3C, 4 cycles after acceptance edge sequence IDLE-ISSUE-WAIT-RESP.
REQ-035 Contention: both valid continuously (0x11, 0x22) for 4 transactions -> grants 0,1,0,1; responses 0xF11,0xF22,0xF11,0xF22.
REQ-036 Backpressure: rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_data held stable, no new ready; accept on 6th cycle then IDLE.
REQ-037 Reset mid-WAIT with LATENCY=4 -> next cycle IDLE, rsp_valid=0, busy=0; no stale response.
REQ-038 Stats (MACHINE_ARB_STATS_EN, CNT_W=2): 5 req1 acceptances -> grant1_cnt=3 (saturated), grant0_cnt=0.
